// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// alu_issue : RV32I decode/issue slot feeding the ALU op/in_a/in_b interface
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("alu_issue supports XLEN=32 only");
    end
  endgenerate

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_SLL    = 4'd2,
    OP_SRL    = 4'd3,
    OP_SRA    = 4'd4,
    OP_SLT    = 4'd5,
    OP_SLTU   = 4'd6,
    OP_XOR    = 4'd7,
    OP_OR     = 4'd8,
    OP_AND    = 4'd9,
    OP_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] c_opc_op    = 7'b0110011;
  localparam logic [6:0] c_opc_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_lui   = 7'b0110111;
  localparam logic [6:0] c_opc_auipc = 7'b0010111;
  localparam logic [6:0] c_f7_base   = 7'b0000000;
  localparam logic [6:0] c_f7_alt    = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_ill;
  logic            dec_we;

  always_comb begin
    dec_op  = OP_ADD;
    dec_a   = rs1_data;
    dec_b   = rs2_data;
    dec_ill = 1'b0;
    case (opcode)
      c_opc_op: begin
        if (funct7 == c_f7_base) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == c_f7_alt && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == c_f7_alt && funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      c_opc_imm: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            dec_b = shamt;
            if (funct7 == c_f7_base) dec_op = OP_SLL;
            else                     dec_ill = 1'b1;
          end
          default: begin
            dec_b = shamt;
            if (funct7 == c_f7_base)     dec_op = OP_SRL;
            else if (funct7 == c_f7_alt) dec_op = OP_SRA;
            else                         dec_ill = 1'b1;
          end
        endcase
      end
      c_opc_lui: begin
        dec_op = OP_PASS_B;
        dec_a  = '0;
        dec_b  = imm_u;
      end
      c_opc_auipc: begin
        dec_op = OP_ADD;
        dec_a  = pc;
        dec_b  = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal encodings still issue, but as a harmless PASS_B of zero.
    if (dec_ill) begin
      dec_op = OP_PASS_B;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  assign dec_we = !dec_ill && (rd != 5'd0);

  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_op_q, out_op_d;
  logic [XLEN-1:0] out_a_q, out_a_d;
  logic [XLEN-1:0] out_b_q, out_b_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_we_q, out_we_d;
  logic            out_illegal_q, out_illegal_d;
  logic            accept;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_rd_d      = out_rd_q;
    out_we_d      = out_we_q;
    out_illegal_d = out_illegal_q;
    // Flush wins over a simultaneous accept; the incoming word is dropped.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_op_d      = dec_op;
      out_a_d       = dec_a;
      out_b_d       = dec_b;
      out_rd_d      = rd;
      out_we_d      = dec_we;
      out_illegal_d = dec_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= 4'd0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_rd_q      <= 5'd0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_rd_q      <= out_rd_d;
      out_we_q      <= out_we_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_rd      = out_rd_q;
  assign out_we      = out_we_q;
  assign out_illegal = out_illegal_q;

endmodule

`default_nettype wire
